// File: rtl/cp0_exc_seq.sv
// cp0_exc_seq: exception / interrupt / ERET / reset sequencer in front of cp0.
// Accepts one event from IDLE, drains the pipeline for FLUSH_CYCLES phi2
// cycles, pulses the cp0 update strobes in COMMIT, then requests a fetch
// redirect.
// Optional feature macro: CP0_EXC_XTLB_EN (XTLB refills use vector offset 0x080).
//
// Redirect handshake: redirect is raised on the edge leaving COMMIT and stays
// high with redirectpc stable until a clk edge samples redirectack=1; that
// edge clears redirect and returns to IDLE (phi2 not required). A reset
// request on the same phi2 edge wins and the ack is ignored.
module cp0_exc_seq #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        phi2,
  input  logic        excreq,
  input  logic [4:0]  exccode,
  input  logic [63:0] wbpc,
  input  logic        wbbd,
  input  logic        exctlbrefill,
  input  logic        excxtlb,
  input  logic [7:0]  intpend,
  input  logic [31:0] cp0status,
  input  logic [63:0] cp0epc,
  input  logic [63:0] cp0errorepc,
  input  logic        eretreq,
  input  logic        coldrstreq,
  input  logic        softrstreq,
  input  logic        redirectack,
  output logic        cp0setexl,
  output logic [5:0]  cp0setexccode,
  output logic [65:0] cp0setepc,
  output logic        cp0coldreset,
  output logic        cp0softreset,
  output logic        cp0eret,
  output logic        flush,
  output logic        busy,
  output logic        redirect,
  output logic [63:0] redirectpc,
  output logic [1:0]  dbgstate
);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_COMMIT, S_REDIRECT} state_t;
  typedef enum logic [1:0] {K_EXC, K_ERET, K_COLD, K_SOFT} kind_t;

  state_t      state;
  kind_t       l_kind;
  logic [4:0]  l_code;
  logic [63:0] l_pc;
  logic        l_bd;
  logic        l_refill;
  logic        l_xtlb;
  logic        l_exl;
  logic        l_erl;
  logic        l_bev;
  logic [3:0]  cnt;

  logic        intreq;
  logic        evt;
  logic        rstreq;
  kind_t       sel_kind;
  logic [4:0]  sel_code;
  logic        sel_refill;
  logic [63:0] vecbase;
  logic [63:0] vecoff;
  logic [63:0] tgt;
  logic        unused_ok;

  assign dbgstate  = state;
  assign intreq    = cp0status[0] & ~cp0status[1] & ~cp0status[2] &
                     (|(intpend & cp0status[15:8]));
  assign rstreq    = coldrstreq | softrstreq;
  assign evt       = rstreq | excreq | intreq | eretreq;
  assign unused_ok = ^{cp0status[31:23], cp0status[21:16], cp0status[7:3], excxtlb};

  // Event selection by priority: cold > soft > exception > interrupt > ERET.
  always_comb begin
    sel_kind   = K_EXC;
    sel_code   = exccode;
    sel_refill = 1'b0;
    if (coldrstreq)      sel_kind   = K_COLD;
    else if (softrstreq) sel_kind   = K_SOFT;
    else if (excreq)     sel_refill = exctlbrefill;
    else if (intreq)     sel_code   = 5'd0;
    else                 sel_kind   = K_ERET;
  end

  // Redirect target from the latched event; ERET picks up EPC/ErrorEPC live.
  always_comb begin
    vecbase = l_bev ? 64'hFFFF_FFFF_BFC0_0200 : 64'hFFFF_FFFF_8000_0000;
    vecoff  = 64'h180;
    if (l_refill && !l_exl) begin
`ifdef CP0_EXC_XTLB_EN
      vecoff = l_xtlb ? 64'h080 : 64'h000;
`else
      vecoff = 64'h000;
`endif
    end
    case (l_kind)
      K_EXC:   tgt = vecbase + vecoff;
      K_ERET:  tgt = l_erl ? cp0errorepc : cp0epc;
      default: tgt = 64'hFFFF_FFFF_BFC0_0000;
    endcase
  end

  // Sequencer FSM with registered strobes, flush, busy and redirect.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_IDLE;
      l_kind        <= K_EXC;
      l_code        <= '0;
      l_pc          <= '0;
      l_bd          <= 1'b0;
      l_refill      <= 1'b0;
      l_xtlb        <= 1'b0;
      l_exl         <= 1'b0;
      l_erl         <= 1'b0;
      l_bev         <= 1'b0;
      cnt           <= '0;
      cp0setexl     <= 1'b0;
      cp0setexccode <= '0;
      cp0setepc     <= '0;
      cp0coldreset  <= 1'b0;
      cp0softreset  <= 1'b0;
      cp0eret       <= 1'b0;
      flush         <= 1'b0;
      busy          <= 1'b0;
      redirect      <= 1'b0;
      redirectpc    <= '0;
    end else begin
      if (phi2) begin
        cp0setexl     <= 1'b0;
        cp0setexccode <= '0;
        cp0setepc     <= '0;
        cp0coldreset  <= 1'b0;
        cp0softreset  <= 1'b0;
        cp0eret       <= 1'b0;
      end
      if (phi2 && state != S_IDLE && rstreq) begin
        // Reset request aborts whatever sequence is in flight.
        state    <= S_FLUSH;
        l_kind   <= coldrstreq ? K_COLD : K_SOFT;
        l_pc     <= wbpc;
        l_refill <= 1'b0;
        cnt      <= 4'(FLUSH_CYCLES);
        flush    <= 1'b1;
        busy     <= 1'b1;
        redirect <= 1'b0;
      end else if (state == S_REDIRECT) begin
        if (redirectack) begin
          state    <= S_IDLE;
          redirect <= 1'b0;
          busy     <= 1'b0;
        end
      end else if (phi2) begin
        case (state)
          S_IDLE: begin
            if (evt) begin
              state    <= S_FLUSH;
              l_kind   <= sel_kind;
              l_code   <= sel_code;
              l_pc     <= wbpc;
              l_bd     <= wbbd;
              l_refill <= sel_refill;
              l_xtlb   <= excxtlb;
              l_exl    <= cp0status[1];
              l_erl    <= cp0status[2];
              l_bev    <= cp0status[22];
              cnt      <= 4'(FLUSH_CYCLES);
              flush    <= 1'b1;
              busy     <= 1'b1;
            end
          end
          S_FLUSH: begin
            if (cnt == 4'd1) begin
              state <= S_COMMIT;
              cnt   <= '0;
              flush <= 1'b0;
              case (l_kind)
                K_EXC: begin
                  cp0setexl     <= 1'b1;
                  cp0setexccode <= {1'b1, l_code};
                  cp0setepc     <= l_exl ? 66'd0 : {1'b1, l_bd, l_pc};
                end
                K_ERET: cp0eret <= 1'b1;
                K_COLD: begin
                  cp0coldreset <= 1'b1;
                  cp0setepc    <= {2'b00, l_pc};
                end
                default: begin
                  cp0softreset <= 1'b1;
                  cp0setepc    <= {2'b00, l_pc};
                end
              endcase
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          S_COMMIT: begin
            state      <= S_REDIRECT;
            redirect   <= 1'b1;
            redirectpc <= tgt;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp0_exc_seq.sv
// Directed testbench for cp0_exc_seq with hand-computed expectations.
module tb_cp0_exc_seq;

  logic        clk = 1'b0;
  logic        rstn, phi2, excreq, wbbd, exctlbrefill, excxtlb;
  logic [4:0]  exccode;
  logic [63:0] wbpc, cp0epc, cp0errorepc;
  logic [7:0]  intpend;
  logic [31:0] cp0status;
  logic        eretreq, coldrstreq, softrstreq, redirectack;
  logic        cp0setexl, cp0coldreset, cp0softreset, cp0eret;
  logic [5:0]  cp0setexccode;
  logic [65:0] cp0setepc;
  logic        flush, busy, redirect;
  logic [63:0] redirectpc;
  logic [1:0]  dbgstate;

  int checks = 0;
  int failures = 0;
  int cold_pulses = 0;
  int c0;

  cp0_exc_seq dut (
    .clk(clk), .rstn(rstn), .phi2(phi2), .excreq(excreq), .exccode(exccode),
    .wbpc(wbpc), .wbbd(wbbd), .exctlbrefill(exctlbrefill), .excxtlb(excxtlb),
    .intpend(intpend), .cp0status(cp0status), .cp0epc(cp0epc),
    .cp0errorepc(cp0errorepc), .eretreq(eretreq), .coldrstreq(coldrstreq),
    .softrstreq(softrstreq), .redirectack(redirectack), .cp0setexl(cp0setexl),
    .cp0setexccode(cp0setexccode), .cp0setepc(cp0setepc),
    .cp0coldreset(cp0coldreset), .cp0softreset(cp0softreset), .cp0eret(cp0eret),
    .flush(flush), .busy(busy), .redirect(redirect), .redirectpc(redirectpc),
    .dbgstate(dbgstate)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) if (rstn && phi2 && cp0coldreset) cold_pulses++;

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    excreq = 1'b0; eretreq = 1'b0; coldrstreq = 1'b0; softrstreq = 1'b0;
    intpend = 8'h00; exctlbrefill = 1'b0; excxtlb = 1'b0; wbbd = 1'b0;
  endtask

  // Requests must already be driven; walks one full sequence to IDLE.
  task automatic run_seq(input string tag, input logic e_exl, input logic [5:0] e_code,
                         input logic e_epcv, input logic [64:0] e_epclo,
                         input logic e_eret, input logic e_cold, input logic e_soft,
                         input logic [63:0] e_pc);
    tick();
    clear_req();
    chk({tag, "_flush0"}, 66'({flush, busy}), 66'(2'b11));
    phi2 = 1'b0;
    tick();
    chk({tag, "_hold"}, 66'({flush, dbgstate}), 66'({1'b1, 2'd1}));
    phi2 = 1'b1;
    tick();
    chk({tag, "_flush1"}, 66'(flush), 66'(1));
    tick();
    chk({tag, "_commit"}, 66'({flush, cp0setexl, cp0eret, cp0coldreset, cp0softreset}),
        66'({1'b0, e_exl, e_eret, e_cold, e_soft}));
    chk({tag, "_code"}, 66'(cp0setexccode), 66'(e_code));
    chk({tag, "_epcv"}, 66'(cp0setepc[65]), 66'(e_epcv));
    if (e_epcv || e_cold || e_soft) chk({tag, "_epc"}, 66'(cp0setepc[64:0]), 66'(e_epclo));
    tick();
    chk({tag, "_redir"}, 66'({redirect, busy, cp0setexl, cp0eret, cp0coldreset,
        cp0softreset, cp0setexccode[5], cp0setepc[65]}), 66'(8'b1100_0000));
    chk({tag, "_rpc"}, 66'(redirectpc), 66'(e_pc));
    phi2 = 1'b0;
    redirectack = 1'b1;
    tick();
    redirectack = 1'b0;
    phi2 = 1'b1;
    chk({tag, "_idle"}, 66'({redirect, busy, flush}), 66'(0));
  endtask

  initial begin
    rstn = 1'b0; phi2 = 1'b1; exccode = '0; wbpc = '0; cp0status = '0;
    cp0epc = '0; cp0errorepc = '0; redirectack = 1'b0;
    clear_req();
    tick(); tick();
    chk("rst_ctl", 66'({cp0setexl, cp0setexccode, cp0coldreset, cp0softreset, cp0eret,
        flush, busy, redirect}), 66'(0));
    chk("rst_epc", cp0setepc, 66'(0));
    chk("rst_rpc", 66'(redirectpc), 66'(0));
    rstn = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_idle", 66'({busy, cp0coldreset}), 66'(0));
    chk("post_rst_nocold", 66'(cold_pulses), 66'(0));

    // TLB refill, BEV=0, EXL=0
    cp0status = 32'h0; excreq = 1'b1; exccode = 5'd2; exctlbrefill = 1'b1;
    wbpc = 64'h1000;
    run_seq("refill", 1'b1, 6'h22, 1'b1, {1'b0, 64'h1000}, 1'b0, 1'b0, 1'b0,
            64'hFFFF_FFFF_8000_0000);

    // Nested exception, EXL=1
    cp0status = 32'h2; excreq = 1'b1; exccode = 5'd10; wbpc = 64'h2000; wbbd = 1'b1;
    run_seq("nested", 1'b1, 6'h2A, 1'b0, 65'd0, 1'b0, 1'b0, 1'b0,
            64'hFFFF_FFFF_8000_0180);

    // Refill with EXL=1 uses the general vector
    cp0status = 32'h2; excreq = 1'b1; exccode = 5'd2; exctlbrefill = 1'b1; wbpc = 64'h2100;
    run_seq("refill_exl", 1'b1, 6'h22, 1'b0, 65'd0, 1'b0, 1'b0, 1'b0,
            64'hFFFF_FFFF_8000_0180);

    // Interrupt, BEV=1
    cp0status = 32'h0040_8001; intpend = 8'h80; wbpc = 64'h3000;
    run_seq("intr", 1'b1, 6'h20, 1'b1, {1'b0, 64'h3000}, 1'b0, 1'b0, 1'b0,
            64'hFFFF_FFFF_BFC0_0380);
    cp0status = 32'h0040_8005; intpend = 8'h80;
    tick(); tick();
    chk("intr_erl_none", 66'({busy, flush}), 66'(0));
    intpend = 8'h00;

    // ERET with ERL=1 and ERL=0
    cp0errorepc = 64'hAAAA_0000_0000_1234; cp0epc = 64'h5555_0000_0000_5678;
    cp0status = 32'h4; eretreq = 1'b1;
    run_seq("eret_erl", 1'b0, 6'h00, 1'b0, 65'd0, 1'b1, 1'b0, 1'b0, 64'hAAAA_0000_0000_1234);
    cp0status = 32'h0; eretreq = 1'b1;
    run_seq("eret_epc", 1'b0, 6'h00, 1'b0, 65'd0, 1'b1, 1'b0, 1'b0, 64'h5555_0000_0000_5678);

    // Exception and ERET together: exception wins
    cp0status = 32'h0; excreq = 1'b1; eretreq = 1'b1; exccode = 5'd5; wbpc = 64'h4000;
    wbbd = 1'b1;
    run_seq("exc_eret", 1'b1, 6'h25, 1'b1, {1'b1, 64'h4000}, 1'b0, 1'b0, 1'b0,
            64'hFFFF_FFFF_8000_0180);

    // XTLB refill
    cp0status = 32'h0; excreq = 1'b1; exccode = 5'd3; exctlbrefill = 1'b1; excxtlb = 1'b1;
    wbpc = 64'h5000;
`ifdef CP0_EXC_XTLB_EN
    run_seq("xtlb", 1'b1, 6'h23, 1'b1, {1'b0, 64'h5000}, 1'b0, 1'b0, 1'b0,
            64'hFFFF_FFFF_8000_0080);
`else
    run_seq("xtlb", 1'b1, 6'h23, 1'b1, {1'b0, 64'h5000}, 1'b0, 1'b0, 1'b0,
            64'hFFFF_FFFF_8000_0000);
`endif

    // Soft reset from IDLE supplies ErrorEPC
    softrstreq = 1'b1; wbpc = 64'h6000;
    run_seq("soft", 1'b0, 6'h00, 1'b0, {1'b0, 64'h6000}, 1'b0, 1'b0, 1'b1,
            64'hFFFF_FFFF_BFC0_0000);

    // Cold reset mid-FLUSH restarts the sequence
    c0 = cold_pulses;
    excreq = 1'b1; exccode = 5'd2; exctlbrefill = 1'b1; wbpc = 64'h7000;
    tick(); clear_req();
    tick();
    chk("abort_pre", 66'(flush), 66'(1));
    coldrstreq = 1'b1;
    tick();
    coldrstreq = 1'b0;
    chk("abort_restart", 66'({flush, busy}), 66'(2'b11));
    tick();
    chk("abort_reload", 66'({flush, cp0coldreset}), 66'(2'b10));
    tick();
    chk("abort_commit", 66'({cp0coldreset, cp0setexl, cp0setexccode, cp0setepc[65]}),
        66'({1'b1, 1'b0, 6'h00, 1'b0}));
    tick();
    chk("abort_rpc", 66'(redirectpc), 66'(64'hFFFF_FFFF_BFC0_0000));
    redirectack = 1'b1; tick(); redirectack = 1'b0;
    chk("abort_pulses", 66'(cold_pulses - c0), 66'(1));

    // Ack and reset request together in REDIRECT: reset wins
    excreq = 1'b1; exccode = 5'd4; wbpc = 64'h8000;
    tick(); clear_req(); tick(); tick(); tick();
    chk("ackrst_redir", 66'(redirect), 66'(1));
    redirectack = 1'b1; softrstreq = 1'b1;
    tick();
    redirectack = 1'b0; softrstreq = 1'b0;
    chk("ackrst_flush", 66'({redirect, flush, busy}), 66'(3'b011));
    tick(); tick();
    chk("ackrst_commit", 66'({cp0softreset, cp0setexl}), 66'(2'b10));
    tick();
    chk("ackrst_rpc", 66'({redirect, redirectpc}), 66'({1'b1, 64'hFFFF_FFFF_BFC0_0000}));
    redirectack = 1'b1; tick(); redirectack = 1'b0;

    // rstn pulse in REDIRECT clears everything at once
    c0 = cold_pulses;
    excreq = 1'b1; exccode = 5'd4; wbpc = 64'h9000;
    tick(); clear_req(); tick(); tick(); tick();
    chk("rstn_pre", 66'(redirect), 66'(1));
    #2 rstn = 1'b0;
    #1;
    chk("rstn_async", 66'({redirect, busy, flush, dbgstate}), 66'(0));
    chk("rstn_rpc", 66'(redirectpc), 66'(0));
    tick();
    rstn = 1'b1;
    tick(); tick();
    chk("rstn_idle", 66'({busy, cold_pulses - c0}), 66'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
